// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: round-robin load/store arbiter with a cache
// lookup stage and a single in-flight transaction to the 10-cycle DataMemory.
module dmem_access_ctrl #(
  parameter int MEM_LATENCY = 10,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_optype,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_pc,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_optype,
  input  logic [31:0] st_data,
  input  logic        flush,
  output logic        cache_lookup,
  output logic        cache_we,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  input  logic        cache_hit,
  input  logic [31:0] cache_rdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic        mem_cache_miss,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_optype,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_pc_ret,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_data,
  output logic        resp_is_store,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_ISSUE, MEM_WAIT, RESP} state_t;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAT_LAST = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic           GRANT_LD = 1'b0;
  localparam logic           GRANT_ST = 1'b1;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    optype_q, optype_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_store_q, is_store_d;
  logic          kill_q, kill_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          load_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_ST;
      pc_q          <= '0;
      addr_q        <= '0;
      optype_q      <= '0;
      wdata_q       <= '0;
      is_store_q    <= 1'b0;
      kill_q        <= 1'b0;
      resp_data_q   <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      optype_q      <= optype_d;
      wdata_q       <= wdata_d;
      is_store_q    <= is_store_d;
      kill_q        <= kill_d;
      resp_data_q   <= resp_data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pc_d           = pc_q;
    addr_d         = addr_q;
    optype_d       = optype_q;
    wdata_d        = wdata_q;
    is_store_d     = is_store_q;
    kill_d         = kill_q;
    resp_data_d    = resp_data_q;
    cnt_d          = cnt_q;
    timeout_err_d  = timeout_err_q;
    ld_ready       = 1'b0;
    st_ready       = 1'b0;
    cache_lookup   = 1'b0;
    cache_we       = 1'b0;
    cache_addr     = '0;
    cache_wdata    = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_cache_miss = 1'b0;
    mem_addr       = '0;
    mem_optype     = '0;
    mem_wdata      = '0;
    mem_pc         = '0;
    resp_valid     = 1'b0;
    resp_pc        = '0;
    resp_data      = '0;
    resp_is_store  = 1'b0;
    load_flush     = flush && !is_store_q;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time gets the grant.
        ld_ready = ld_valid && (!st_valid || last_grant_q == GRANT_ST);
        st_ready = st_valid && (!ld_valid || last_grant_q == GRANT_LD);
        if (ld_ready) begin
          pc_d         = ld_pc;
          addr_d       = ld_addr;
          optype_d     = ld_optype;
          wdata_d      = '0;
          is_store_d   = 1'b0;
          last_grant_d = GRANT_LD;
          resp_data_d  = '0;
          state_d      = LOOKUP;
        end else if (st_ready) begin
          pc_d         = st_pc;
          addr_d       = st_addr;
          optype_d     = st_optype;
          wdata_d      = st_data;
          is_store_d   = 1'b1;
          last_grant_d = GRANT_ST;
          resp_data_d  = '0;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        cache_lookup = 1'b1;
        cache_addr   = addr_q;
        if (is_store_q) begin
          cache_we    = 1'b1;
          cache_wdata = wdata_q;
          state_d     = MEM_ISSUE;
        end else if (cache_hit) begin
          resp_data_d = cache_rdata;
          state_d     = RESP;
        end else begin
          state_d = MEM_ISSUE;
        end
      end
      MEM_ISSUE: begin
        mem_read_en  = !is_store_q;
        mem_write_en = is_store_q;
        cnt_d        = '0;
        state_d      = MEM_WAIT;
      end
      MEM_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Read data tagged with another PC belongs to nobody here; ignore it.
        if (!is_store_q && mem_data_valid && mem_pc_ret == pc_q) begin
          resp_data_d = mem_rdata;
          state_d     = RESP;
        end else if (is_store_q && cnt_q == LAT_LAST) begin
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          resp_data_d   = '0;
          state_d       = RESP;
        end
      end
      RESP: begin
        resp_valid    = !kill_q && !load_flush;
        resp_pc       = resp_valid ? pc_q : '0;
        resp_data     = resp_valid ? resp_data_q : '0;
        resp_is_store = resp_valid && is_store_q;
        kill_d        = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == MEM_ISSUE || state_q == MEM_WAIT) begin
      mem_cache_miss = 1'b1;
      mem_addr       = addr_q;
      mem_optype     = optype_q;
      mem_wdata      = wdata_q;
      mem_pc         = pc_q;
    end

    // A squashed load keeps draining memory but its response is dropped.
    if (load_flush && state_q inside {LOOKUP, MEM_ISSUE, MEM_WAIT}) begin
      kill_d = 1'b1;
    end
  end

  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl: vector table of single
// transactions plus hand-written arbitration, flush, timeout and reset sequences.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_pc, ld_addr;
  logic [3:0]  ld_optype;
  logic        st_valid, st_ready;
  logic [31:0] st_pc, st_addr;
  logic [3:0]  st_optype;
  logic [31:0] st_data;
  logic        flush;
  logic        cache_lookup, cache_we;
  logic [31:0] cache_addr, cache_wdata;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        mem_read_en, mem_write_en, mem_cache_miss;
  logic [31:0] mem_addr;
  logic [3:0]  mem_optype;
  logic [31:0] mem_wdata, mem_pc;
  logic        mem_data_valid;
  logic [31:0] mem_pc_ret, mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_pc, resp_data;
  logic        resp_is_store, busy, timeout_err;

  logic        mem_respond;
  logic [31:0] mem_ret_data;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        is_store;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  optype;
    logic [31:0] data;
    logic        hit;
    logic [31:0] crdata;
    logic [31:0] mrdata;
    logic        respond;
    int          lat;
    logic [31:0] exp_data;
    int          rd;
    int          wr;
    int          we;
    int          mem_cyc;
  } vec_t;

  vec_t vecs[4];
  vec_t to_vec;

  dmem_access_ctrl dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_pc(ld_pc), .ld_addr(ld_addr),
    .ld_optype(ld_optype),
    .st_valid(st_valid), .st_ready(st_ready), .st_pc(st_pc), .st_addr(st_addr),
    .st_optype(st_optype), .st_data(st_data),
    .flush(flush),
    .cache_lookup(cache_lookup), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_cache_miss(mem_cache_miss), .mem_addr(mem_addr), .mem_optype(mem_optype),
    .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .mem_data_valid(mem_data_valid), .mem_pc_ret(mem_pc_ret), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_data(resp_data),
    .resp_is_store(resp_is_store), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory model: answers a read 10 cycles after the pulse, tagged with its PC.
  initial begin
    logic [31:0] req_pc;
    mem_data_valid = 1'b0;
    mem_pc_ret     = '0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (mem_read_en && mem_respond) begin
        req_pc = mem_pc;
        repeat (10) @(negedge clk);
        mem_data_valid = 1'b1;
        mem_pc_ret     = req_pc;
        mem_rdata      = mem_ret_data;
        @(negedge clk);
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
      end
    end
  end

  function automatic logic anyOutput();
    return |{ld_ready, st_ready, cache_lookup, cache_we, cache_addr, cache_wdata,
             mem_read_en, mem_write_en, mem_cache_miss, mem_addr, mem_optype,
             mem_wdata, mem_pc, resp_valid, resp_pc, resp_data, resp_is_store,
             busy, timeout_err};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    ld_valid = 1'b0;
    st_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("reset_outputs", 32'(anyOutput()), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One transaction from handshake to completion, tallying every strobe seen.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat = -1;
    int n_rd = 0, n_wr = 0, n_we = 0, n_lk = 0, n_mem = 0, n_hold = 0, n_caddr = 0;
    int n_rdy = 0;
    logic [31:0] got_pc = '0, got_data = '0;
    logic        got_st = 1'b0;
    logic [31:0] exp_wdata;
    exp_wdata = v.is_store ? v.data : 32'd0;
    @(negedge clk);
    cache_hit    = v.hit;
    cache_rdata  = v.crdata;
    mem_ret_data = v.mrdata;
    mem_respond  = v.respond;
    if (v.is_store) begin
      st_valid = 1'b1; st_pc = v.pc; st_addr = v.addr; st_optype = v.optype;
      st_data = v.data;
    end else begin
      ld_valid = 1'b1; ld_pc = v.pc; ld_addr = v.addr; ld_optype = v.optype;
    end
    #1;
    checkOutput({tag, "_ready"}, 32'(v.is_store ? st_ready : ld_ready), 32'd1);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        ld_valid = 1'b0;
        st_valid = 1'b0;
      end
      if (cache_lookup) begin
        n_lk++;
        if (cache_addr !== v.addr) n_caddr++;
      end
      if (cache_we) begin
        n_we++;
        if (cache_wdata !== v.data) n_caddr++;
      end
      if (mem_read_en) n_rd++;
      if (mem_write_en) n_wr++;
      if (ld_ready || st_ready) n_rdy++;
      if (mem_cache_miss) begin
        n_mem++;
        if (mem_addr !== v.addr || mem_optype !== v.optype || mem_pc !== v.pc ||
            mem_wdata !== exp_wdata) n_hold++;
      end
      if (resp_valid) begin
        lat      = n;
        got_pc   = resp_pc;
        got_data = resp_data;
        got_st   = resp_is_store;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(v.lat));
    checkOutput({tag, "_resp_pc"}, got_pc, v.pc);
    checkOutput({tag, "_resp_data"}, got_data, v.exp_data);
    checkOutput({tag, "_resp_is_store"}, 32'(got_st), 32'(v.is_store));
    checkOutput({tag, "_lookups"}, 32'(n_lk), 32'd1);
    checkOutput({tag, "_cache_bus"}, 32'(n_caddr), 32'd0);
    checkOutput({tag, "_cache_we"}, 32'(n_we), 32'(v.we));
    checkOutput({tag, "_rd_pulses"}, 32'(n_rd), 32'(v.rd));
    checkOutput({tag, "_wr_pulses"}, 32'(n_wr), 32'(v.wr));
    checkOutput({tag, "_mem_cycles"}, 32'(n_mem), 32'(v.mem_cyc));
    checkOutput({tag, "_mem_hold"}, 32'(n_hold), 32'd0);
    checkOutput({tag, "_ready_busy"}, 32'(n_rdy), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int grants[4];
    int n_grant, n_resp, n_bad;
    logic busy13, busy14;

    //          st  pc       addr      op     data          hit  crdata        mrdata        rsp lat exp_data      rd wr we mem
    vecs[0] = '{1'b0, 32'h40, 32'h5,   4'd8,  32'h0,        1'b1, 32'hDEADBEEF, 32'h0,       1'b1, 2, 32'hDEADBEEF, 0, 0, 0, 0};
    vecs[1] = '{1'b0, 32'h44, 32'h3,   4'd8,  32'h0,        1'b0, 32'h0,       32'h1234,     1'b1, 13, 32'h1234,    1, 0, 0, 11};
    vecs[2] = '{1'b1, 32'h60, 32'h7,   4'd10, 32'hA5A5A5A5, 1'b0, 32'h0,       32'h0,        1'b1, 13, 32'h0,       0, 1, 1, 11};
    vecs[3] = '{1'b1, 32'h64, 32'h100, 4'd9,  32'h5A,       1'b1, 32'h11111111, 32'h0,       1'b1, 13, 32'h0,       0, 1, 1, 11};
    to_vec  = '{1'b0, 32'h80, 32'h9,   4'd7,  32'h0,        1'b0, 32'h0,       32'h0,        1'b0, 19, 32'h0,       1, 0, 0, 17};

    rstn = 1'b1; ld_valid = 1'b0; st_valid = 1'b0; flush = 1'b0;
    ld_pc = '0; ld_addr = '0; ld_optype = '0;
    st_pc = '0; st_addr = '0; st_optype = '0; st_data = '0;
    cache_hit = 1'b0; cache_rdata = '0; mem_respond = 1'b0; mem_ret_data = '0;
    doReset();

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Both ports held valid from reset: grants must alternate starting with the load.
    doReset();
    cache_hit = 1'b1; cache_rdata = 32'h0BAD; mem_respond = 1'b0;
    ld_pc = 32'h100; ld_addr = 32'h20; ld_optype = 4'd8;
    st_pc = 32'h200; st_addr = 32'h24; st_optype = 4'd10; st_data = 32'h77;
    @(negedge clk);
    ld_valid = 1'b1; st_valid = 1'b1;
    n_grant = 0; n_resp = 0; n_bad = 0;
    for (int c = 0; c < 200 && n_grant < 4; c++) begin
      #1;
      if (ld_ready && st_ready) n_bad++;
      if (busy && (ld_ready || st_ready)) n_bad++;
      if (resp_valid) n_resp++;
      if (ld_ready) grants[n_grant++] = 0;
      else if (st_ready) grants[n_grant++] = 1;
      @(negedge clk);
    end
    ld_valid = 1'b0; st_valid = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (resp_valid) n_resp++;
      @(negedge clk);
    end
    checkOutput("arb_grant_count", 32'(n_grant), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    checkOutput("arb_ready_rules", 32'(n_bad), 32'd0);
    checkOutput("arb_responses", 32'(n_resp), 32'd4);

    // Load miss flushed three cycles into the wait: memory drains, no response.
    cache_hit = 1'b0; mem_respond = 1'b1; mem_ret_data = 32'h7777;
    ld_pc = 32'h50; ld_addr = 32'h3; ld_optype = 4'd8;
    ld_valid = 1'b1;
    #1;
    checkOutput("flush_ready", 32'(ld_ready), 32'd1);
    n_resp = 0; busy13 = 1'b0; busy14 = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 1) ld_valid = 1'b0;
      flush = (n == 6);
      #1;
      if (resp_valid) n_resp++;
      if (n == 13) busy13 = busy;
      if (n == 14) busy14 = busy;
    end
    flush = 1'b0;
    checkOutput("flush_no_resp", 32'(n_resp), 32'd0);
    checkOutput("flush_busy_resp", 32'(busy13), 32'd1);
    checkOutput("flush_busy_drop", 32'(busy14), 32'd0);
    applyStimulus(vecs[0], "after_flush");

    checkOutput("timeout_err_clear", 32'(timeout_err), 32'd0);
    applyStimulus(to_vec, "timeout");
    checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);

    // Reset in the middle of a memory wait abandons the transaction silently.
    @(negedge clk);
    ld_pc = 32'h90; ld_addr = 32'hB; ld_optype = 4'd8; ld_valid = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("midwait_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("midwait_reset_outputs", 32'(anyOutput()), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    n_resp = 0; n_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
      if (busy) n_bad++;
    end
    checkOutput("midwait_no_resp", 32'(n_resp), 32'd0);
    checkOutput("midwait_idle", 32'(n_bad), 32'd0);
    applyStimulus(vecs[1], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Single-port access controller and arbiter in front of the data cache and the 10-cycle DataMemory.
- Accepts load requests from the LSQ issue port and committed store requests from the ROB.
- Grants one request at a time, round-robin between the two ports; the memory port allows only one transaction in flight.
- Each transaction does a cache lookup first. Load misses and all stores (write-through) go to memory. Exactly one completion response is returned per transaction.

Parameters:
MEM_LATENCY, 10, cycles from mem_read_en/mem_write_en pulse to data valid or store completion
TIMEOUT, 16, wait-cycle limit in MEM_WAIT before abort; must be > MEM_LATENCY

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
ld_valid  in  1  load request present
ld_ready  out  1  load accepted when ld_valid&&ld_ready
ld_pc  in  32  load instruction PC
ld_addr  in  32  load address
ld_optype  in  4  LB=7 / LW=8
st_valid  in  1  store request present
st_ready  out  1  store accepted when st_valid&&st_ready
st_pc  in  32  store instruction PC
st_addr  in  32  store address
st_optype  in  4  SB=9 / SW=10
st_data  in  32  store data
flush  in  1  squash in-flight load response
cache_lookup  out  1  cache probe strobe
cache_we  out  1  store update of cache (write-through)
cache_addr  out  32  probe address
cache_wdata  out  32  store data to cache
cache_hit  in  1  same-cycle hit (combinational cache)
cache_rdata  in  32  same-cycle hit data
mem_read_en  out  1  1-cycle read pulse
mem_write_en  out  1  1-cycle write pulse
mem_cache_miss  out  1  high throughout memory phase
mem_addr  out  32  held stable whole memory phase
mem_optype  out  4  held stable whole memory phase
mem_wdata  out  32  held stable whole memory phase
mem_pc  out  32  held stable whole memory phase
mem_data_valid  in  1  memory read data valid
mem_pc_ret  in  32  PC returned with memory data
mem_rdata  in  32  memory read data
resp_valid  out  1  1-cycle completion pulse
resp_pc  out  32  completing PC
resp_data  out  32  load data; 0 for stores
resp_is_store  out  1  completion belongs to a store
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=STORE, so the first tie goes to the load port. Reset mid-transaction abandons it; no response is issued.
- States: IDLE, LOOKUP, MEM_ISSUE, MEM_WAIT, RESP.
- ld_ready/st_ready are combinational and only asserted in IDLE.
  - One valid: that port is ready.
  - Both valid: the port not equal to last_grant is ready; the other ready is 0.
- Accept latches pc/addr/optype/data and the is_store flag, updates last_grant, then IDLE->LOOKUP.
- LOOKUP, 1 cycle:
  - cache_lookup=1 with the latched address.
  - Store: cache_we=1, then ->MEM_ISSUE regardless of hit.
  - Load hit: resp_data<=cache_rdata, ->RESP.
  - Load miss: ->MEM_ISSUE.
- MEM_ISSUE, 1 cycle: mem_read_en (load) or mem_write_en (store)=1; mem_cache_miss=1; wait counter cleared; ->MEM_WAIT.
- MEM_WAIT:
  - mem_* address/optype/wdata/pc and mem_cache_miss held constant; enables are 0.
  - Counter increments each cycle.
  - Load completes on mem_data_valid && mem_pc_ret==latched pc: resp_data<=mem_rdata, ->RESP. A valid with mismatched PC is ignored.
  - Store completes when counter==MEM_LATENCY-1, ->RESP.
  - If counter reaches TIMEOUT-1 first: set timeout_err, resp_data=0, ->RESP.
- RESP, 1 cycle: resp_valid=1 with latched pc and is_store; ->IDLE.
- Load hit latency: accept to resp_valid is 2 cycles.
- Miss/store: resp_valid asserts MEM_LATENCY+1 cycles after the mem enable pulse.
- Back-to-back: the next accept is possible in the IDLE cycle after RESP.
- flush:
  - Load in LOOKUP/MEM_ISSUE/MEM_WAIT/RESP: sets a kill flag. The transaction still runs to completion to drain memory, but resp_valid is suppressed.
  - flush has no effect on stores.
  - flush in IDLE is a no-op.
  - The kill flag is cleared on return to IDLE.
- Only one transaction is outstanding at any time; requests held at valid are not lost.

Test Plan:
- Load LW addr 5, pc 0x40, cache_hit=1, cache_rdata=0xDEADBEEF -> resp_valid 2 cycles after accept, resp_pc=0x40, resp_data=0xDEADBEEF; no mem_read_en.
- Load miss addr 3, pc 0x44; memory returns 0x1234 with pc 0x44 after 10 cycles -> one mem_read_en pulse; mem_addr held at 3 for the entire wait; resp_data=0x1234.
- Store SW addr 7, data 0xA5A5A5A5 -> cache_we pulse, mem_write_en pulse, mem_wdata stable ≥10 cycles; resp_valid with resp_is_store=1 and resp_data=0, 11 cycles after the pulse.
- ld_valid and st_valid both held high for 4 transactions from reset -> grant order LD, ST, LD, ST; ready deasserted while busy.
- Load miss, then flush 3 cycles into MEM_WAIT -> no resp_valid; busy drops after completion; next request accepted normally.
- Load miss with memory never asserting valid -> timeout_err=1 after 16 wait cycles; resp_valid with resp_data=0; rstn low mid-wait -> all outputs 0, state IDLE.
